// File: rtl/ce_scheduler.sv
// ce_scheduler: per-channel clock-enable dividers feeding a round-robin arbiter that drives a one-hot o_ce strobe.
// Latency: a tick (cnt==0) shows in o_pend next cycle; the earliest o_ce follows one cycle later (2 cycles minimum).
// Backpressure: none; a tick on a still-pending channel merges into the flag. With CE_SCHED_OVF_EN defined it also sets sticky o_ovf.
module ce_scheduler #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int CHW   = $clog2(NCH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [CHW-1:0]   i_wr_ch,
  input  logic [WIDTH-1:0] i_wr_div,
  input  logic [NCH-1:0]   i_ch_en,
  output logic [NCH-1:0]   o_ce,
  output logic [NCH-1:0]   o_pend,
  output logic [NCH-1:0]   o_ovf
);

  logic [WIDTH-1:0] div_reg [NCH];
  logic [WIDTH-1:0] cnt     [NCH];
  logic [WIDTH-1:0] cnt_nxt [NCH];
  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   pend_nxt;
  logic [CHW-1:0]   last;
  logic [CHW-1:0]   gidx;
  logic             gvld;

  // Decode the config write; derive each channel's tick and next counter value (write beats run/idle).
  always_comb begin
    wr_hit = '0;
    tick   = '0;
    for (int c = 0; c < NCH; c++) begin
      cnt_nxt[c] = cnt[c];
      wr_hit[c]  = i_wr_en && (i_wr_ch == CHW'(c));
      tick[c]    = i_ch_en[c] && (cnt[c] == '0) && !wr_hit[c];
      if (wr_hit[c])
        cnt_nxt[c] = i_wr_div;
      else if (!i_ch_en[c] || (cnt[c] == '0))
        cnt_nxt[c] = div_reg[c];
      else
        cnt_nxt[c] = cnt[c] - WIDTH'(1);
    end
  end

  // Round-robin pick: the lowest requester above last wins, otherwise the lowest overall (wrap).
  // A channel that is disabled or being written this cycle cannot be granted; its flag is dropped instead.
  always_comb begin
    req   = o_pend & i_ch_en & ~wr_hit;
    gvld  = 1'b0;
    gidx  = last;
    grant = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (req[c]) begin
        gvld = 1'b1;
        gidx = CHW'(c);
      end
    end
    for (int c = NCH - 1; c >= 0; c--) begin
      if (req[c] && (CHW'(c) > last))
        gidx = CHW'(c);
    end
    for (int c = 0; c < NCH; c++)
      grant[c] = gvld && (gidx == CHW'(c));
  end

  // Pending flags: cleared by a write or disable; a new tick outranks a grant, so a tick in the grant cycle stays queued.
  always_comb begin
    pend_nxt = o_pend;
    for (int c = 0; c < NCH; c++) begin
      if (wr_hit[c] || !i_ch_en[c])
        pend_nxt[c] = 1'b0;
      else if (tick[c])
        pend_nxt[c] = 1'b1;
      else if (grant[c])
        pend_nxt[c] = 1'b0;
    end
  end

  // Register dividers, counters, pending flags, the strobe and the round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NCH; c++) begin
        div_reg[c] <= '0;
        cnt[c]     <= '0;
      end
      o_pend <= '0;
      o_ce   <= '0;
      last   <= CHW'(NCH - 1);
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_hit[c])
          div_reg[c] <= i_wr_div;
        cnt[c] <= cnt_nxt[c];
      end
      o_pend <= pend_nxt;
      o_ce   <= grant;
      if (gvld)
        last <= gidx;
    end
  end

`ifdef CE_SCHED_OVF_EN
  logic [NCH-1:0] ovf_q;

  // Sticky flag for a tick that lands on a pending flag that is not drained in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_hit[c])
          ovf_q[c] <= 1'b0;
        else if (tick[c] && o_pend[c] && !grant[c])
          ovf_q[c] <= 1'b1;
      end
    end
  end

  assign o_ovf = ovf_q;
`else
  assign o_ovf = '0;
`endif

endmodule
